// File: rtl/pipelined_hybrid_adder.sv
// Two-stage valid/ready hybrid adder: OR-approximated low L bits with a speculated carry, exact above.
// Optional error monitor (exact-sum compare, err_flag, saturating err_count) under HYBRID_ADDER_ERR_MON_EN.
module pipelined_hybrid_adder #(
  parameter int WIDTH = 32,
  parameter int LMAX  = 16,
  parameter int LW    = $clog2(LMAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic [LW-1:0]    approx_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef HYBRID_ADDER_ERR_MON_EN
  ,
  output logic             err_flag,
  output logic [15:0]      err_count,
  input  logic             clr_stats
`endif
);

  localparam int H = WIDTH / 2;

  logic           s1_valid_q, s2_valid_q;
  logic           s1_adv, s2_adv;

  logic [LW-1:0]  len_clamped;
  logic [H-1:0]   a_lo, b_lo;
  logic [H-1:0]   mask;
  logic [H-1:0]   top_bit;
  logic           spec_c;
  logic [H:0]     lo_part;
  logic [H-1:0]   s1_lo_d, s1_lo_q;
  logic           s1_c_d, s1_c_q;
  logic [H-1:0]   s1_ahi_q, s1_bhi_q;

  logic [H:0]     hi_part;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic           cout_d, cout_q;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign s1_adv    = !s1_valid_q || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

  // mask covers the approximate bits [L-1:0]; it is empty in exact mode or when L is zero,
  // so the same adder serves both modes. top_bit isolates bit L-1 for the speculated carry.
  always_comb begin
    a_lo        = a[H-1:0];
    b_lo        = b[H-1:0];
    len_clamped = (approx_len > LW'(LMAX)) ? LW'(LMAX) : approx_len;
    mask        = mode ? ~({H{1'b1}} << len_clamped) : '0;
    top_bit     = mask ^ (mask >> 1);
    spec_c      = |(a_lo & b_lo & top_bit);
    lo_part     = {1'b0, a_lo & ~mask} + {1'b0, b_lo & ~mask}
                + (spec_c ? {top_bit, 1'b0} : '0);
    s1_lo_d     = ((a_lo | b_lo) & mask) | lo_part[H-1:0];
    s1_c_d      = lo_part[H];
  end

  always_comb begin
    hi_part = {1'b0, s1_ahi_q} + {1'b0, s1_bhi_q} + (H + 1)'(s1_c_q);
    sum_d   = {hi_part[H-1:0], s1_lo_q};
    cout_d  = hi_part[H];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_c_q     <= 1'b0;
      s1_ahi_q   <= '0;
      s1_bhi_q   <= '0;
      s2_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_lo_q  <= s1_lo_d;
          s1_c_q   <= s1_c_d;
          s1_ahi_q <= a[WIDTH-1:H];
          s1_bhi_q <= b[WIDTH-1:H];
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
        end
      end
    end
  end

`ifdef HYBRID_ADDER_ERR_MON_EN
  logic [WIDTH:0] s1_exact_d, s1_exact_q;
  logic           err_d, err_q;
  logic [15:0]    err_count_q;

  assign s1_exact_d = {1'b0, a} + {1'b0, b};
  assign err_d      = {cout_d, sum_d} != s1_exact_q;
  assign err_flag   = s2_valid_q & err_q;
  assign err_count  = err_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_exact_q  <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      if (s1_adv && in_valid) begin
        s1_exact_q <= s1_exact_d;
      end
      if (s2_adv && s1_valid_q) begin
        err_q <= err_d;
      end
      if (clr_stats) begin
        err_count_q <= '0;
      end else if (out_valid && out_ready && err_flag && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_hybrid_adder.sv
// Bench for pipelined_hybrid_adder: directed vector table, backpressure/reset sequences and a random stream
// against an arithmetic reference model. Monitor ports are exercised when HYBRID_ADDER_ERR_MON_EN is defined.
module tb_pipelined_hybrid_adder;

  localparam int W    = 32;
  localparam int LMAX = 16;
  localparam int LW   = $clog2(LMAX + 1);
  localparam int NRAND = 300;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          mode;
  logic [LW-1:0] approx_len;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
`ifdef HYBRID_ADDER_ERR_MON_EN
  logic          err_flag;
  logic [15:0]   err_count;
  logic          clr_stats;
`endif

  pipelined_hybrid_adder #(.WIDTH(W), .LMAX(LMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .mode       (mode),
    .approx_len (approx_len),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout)
`ifdef HYBRID_ADDER_ERR_MON_EN
    ,
    .err_flag   (err_flag),
    .err_count  (err_count),
    .clr_stats  (clr_stats)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W:0] r;
    logic       e;
  } exp_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          m;
    logic [LW-1:0] l;
    logic [W:0]    r;
    logic          e;
    string         name;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          exp_cnt = 0;
  exp_t        q[$];
  logic        held_valid = 1'b0;
  logic [W:0]  held_res;
  logic        last_in_ready, last_out_valid, last_acc;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Approximate addition expressed directly on whole integers: OR below L, exact sum above with carry bit L-1.
  function automatic exp_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic vm, input int unsigned vl);
    exp_t            e;
    int unsigned     l;
    longint unsigned av, bv, exact, c, hi, res;
    l     = (vl > LMAX) ? LMAX : vl;
    av    = 64'(va);
    bv    = 64'(vb);
    exact = av + bv;
    if (!vm || l == 0) begin
      res = exact;
    end else begin
      c   = (av >> (l - 1)) & (bv >> (l - 1)) & 64'd1;
      hi  = (av >> l) + (bv >> l) + c;
      res = (hi << l) | ((av | bv) & ((64'd1 << l) - 64'd1));
    end
    e.r = res[W:0];
    e.e = (res != exact);
    return e;
  endfunction

  // One cycle: inputs were set just after a negedge; handshakes are evaluated before the next posedge.
  task automatic tick();
    exp_t e;
    #1;
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
    last_acc       = in_valid && in_ready;
    if (held_valid) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_hold", 64'({cout, sum}), 64'(held_res));
    end
    held_valid = out_valid && !out_ready;
    held_res   = {cout, sum};
    if (last_acc) q.push_back(model(a, b, mode, int'(approx_len)));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("spurious_result", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("stream_result", 64'({cout, sum}), 64'(e.r));
`ifdef HYBRID_ADDER_ERR_MON_EN
        chk("stream_err_flag", 64'(err_flag), 64'(e.e));
        if (e.e && exp_cnt != 65535) exp_cnt++;
`endif
      end
    end
    @(negedge clk);
`ifdef HYBRID_ADDER_ERR_MON_EN
    chk("stream_err_count", 64'(err_count), 64'(exp_cnt));
`endif
  endtask

  // Single beat through an empty pipe; control inputs are scrambled after acceptance.
  task automatic vec(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vm,
                     input logic [LW-1:0] vl, input logic [W:0] req, input logic req_err,
                     input logic clr, input string name);
    a = va; b = vb; mode = vm; approx_len = vl;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; mode = ~vm; approx_len = LW'(7);
    chk({name, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_sum"}, 64'({cout, sum}), 64'(req));
`ifdef HYBRID_ADDER_ERR_MON_EN
    chk({name, "_err_flag"}, 64'(err_flag), 64'(req_err));
    clr_stats = clr;
`endif
    @(posedge clk); #1;
`ifdef HYBRID_ADDER_ERR_MON_EN
    clr_stats = 1'b0;
    if (clr) exp_cnt = 0;
    else if (req_err && exp_cnt != 65535) exp_cnt++;
    chk({name, "_err_count"}, 64'(err_count), 64'(exp_cnt));
`else
    if (clr && req_err) exp_cnt = 0;
`endif
    chk({name, "_consumed"}, 64'(out_valid), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int sent;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; mode = 1'b0; approx_len = '0;
`ifdef HYBRID_ADDER_ERR_MON_EN
    clr_stats = 1'b0;
`endif
    tbl[0] = '{32'h0000000F, 32'h00000001, 1'b1, LW'(4),  33'h0_0000000F, 1'b1, "approx_nocarry"};
    tbl[1] = '{32'h00008000, 32'h00008000, 1'b1, LW'(16), 33'h0_00018000, 1'b1, "approx_speccarry"};
    tbl[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, LW'(0),  33'h1_00000000, 1'b0, "exact_wrap"};
    tbl[3] = '{32'h000000FF, 32'h00000001, 1'b1, LW'(20), 33'h0_000000FF, 1'b1, "clamp"};
    tbl[4] = '{32'h12345678, 32'h11111111, 1'b1, LW'(0),  33'h0_23456789, 1'b0, "len_zero"};
    tbl[5] = '{32'h00000001, 32'h00000001, 1'b1, LW'(1),  33'h0_00000003, 1'b1, "len_one"};
    tbl[6] = '{32'hFFFF0000, 32'h00010000, 1'b1, LW'(16), 33'h1_00000000, 1'b0, "approx_cout"};
    tbl[7] = '{32'h000000F0, 32'h0000000F, 1'b1, LW'(8),  33'h0_000000FF, 1'b0, "approx_exactlow"};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_sum", 64'({cout, sum}), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
`ifdef HYBRID_ADDER_ERR_MON_EN
    chk("reset_err_flag", 64'(err_flag), 64'd0);
    chk("reset_err_count", 64'(err_count), 64'd0);
`endif
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      vec(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].l, tbl[i].r, tbl[i].e, 1'b0, tbl[i].name);
    vec(32'h0000000F, 32'h00000001, 1'b1, LW'(4), 33'h0_0000000F, 1'b1, 1'b1, "clr_priority");

    // Backpressure: two beats fill the pipe, then simultaneous consume/accept at full rate.
    out_ready = 1'b0; in_valid = 1'b1; b = '0; mode = 1'b0; approx_len = '0;
    for (int k = 0; k < 4; k++) begin
      a = 32'h100 + 32'(k);
      tick();
      chk("bp_in_ready", 64'(last_in_ready), (k < 2) ? 64'd1 : 64'd0);
    end
    out_ready = 1'b1;
    for (int k = 4; k < 8; k++) begin
      a = 32'h100 + 32'(k);
      tick();
      chk("bp_out_valid", 64'(last_out_valid), 64'd1);
      chk("bp_full_in_ready", 64'(last_in_ready), 64'd1);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && q.size() != 0; k++) tick();
    chk("bp_drain", 64'(q.size()), 64'd0);

    sent = 0;
    cyc  = 0;
    while (cyc < 5000 && !(sent >= NRAND && q.size() == 0)) begin
      in_valid   = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      a          = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      b          = $urandom;
      mode       = 1'($urandom_range(0, 1));
      approx_len = LW'($urandom_range(0, 20));
      out_ready  = ($urandom_range(0, 3) != 0);
      tick();
      if (last_acc) sent++;
      cyc++;
    end
    chk("random_complete", 64'(sent == NRAND && q.size() == 0), 64'd1);

    // Reset with two beats in flight.
    out_ready = 1'b0; in_valid = 1'b1; b = 32'h1; mode = 1'b0; approx_len = '0;
    a = 32'h55; tick();
    a = 32'h66; tick();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'({cout, sum}), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    q.delete();
    held_valid = 1'b0;
    exp_cnt = 0;
`ifdef HYBRID_ADDER_ERR_MON_EN
    chk("midrst_err_count", 64'(err_count), 64'd0);
`endif
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("midrst_no_stale", 64'(last_out_valid), 64'd0);
    end
    vec(32'd3, 32'd4, 1'b0, LW'(0), 33'd7, 1'b0, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_hybrid_adder.md
Name: pipelined_hybrid_adder

Overview:
- Two-stage pipelined, runtime-configurable hybrid approximate adder. It is the successor to the combinational split adder, which used an approximate low part feeding a carry into an exact ripple high part.
- Adds a valid/ready handshake, a per-transaction exact/approximate mode, and a per-transaction approximate-part length.
- Sits on datapath streams where accuracy is traded for energy on a per-operand basis.

Parameters:
- WIDTH, 32: total operand/sum width; must be even.
- LMAX, 16: maximum approximate low-part length; must satisfy 1 <= LMAX <= WIDTH/2.
- LW, $clog2(LMAX+1): width of the approx_len port (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- mode  input  1  0 = exact, 1 = approximate
- approx_len  input  LW  approximate low-part length L (clamped to LMAX)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result sum
- cout  output  1  result carry-out

Behaviour:
- Function. Let L = min(approx_len, LMAX).
  - If mode==0 or L==0: {cout,sum} = a + b, exact.
  - Otherwise:
    - sum[L-1:0] = a[L-1:0] | b[L-1:0] (bitwise OR).
    - Speculated carry c = a[L-1] & b[L-1].
    - {cout, sum[WIDTH-1:L]} = a[WIDTH-1:L] + b[WIDTH-1:L] + c, exact.
- Pipeline partition, H = WIDTH/2.
  - Stage 1 computes sum[H-1:0] and the carry into bit H. Approximation applies only inside [L-1:0], always within stage 1.
  - Stage 1 registers the low result, the carry, and the upper operand halves.
  - Stage 2 computes sum[WIDTH-1:H] and cout from the registered values.
  - mode and approx_len are sampled with the operands at acceptance and travel with the beat. Changing them later does not affect in-flight beats.
- Handshake.
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational).
  - Latency: a result is presented 2 cycles after acceptance when there is no backpressure. Sustained throughput is 1 beat/cycle.
  - While out_valid && !out_ready, sum and cout hold stable.
  - Up to 2 beats are buffered. With both stages full and out_ready=0, in_ready=0.
  - Order is preserved. No beat is dropped or duplicated.
  - Simultaneous consume and accept with a full pipe is legal: both stages advance in the same cycle and in_ready stays 1.
- Reset (rst=1 at a clock edge):
  - s1_valid=0, s2_valid=0, out_valid=0, sum=0, cout=0.
  - In-flight beats are discarded.
  - in_ready reads 1 in the cycle after reset is released.
  - Data registers are cleared to 0.
- Overflow: the carry beyond WIDTH appears only on cout. sum wraps modulo 2^WIDTH.

Optional Feature:
- Macro: HYBRID_ADDER_ERR_MON_EN.
- When defined:
  - Stage 1 also computes the exact sum a+b for every beat and carries it alongside the approximate result.
  - Extra ports:
    - err_flag (output, 1): high with out_valid when {cout,sum} differs from the exact {cout,sum}.
    - err_count (output, 16): saturating count of consumed beats with err_flag=1; holds at 0xFFFF.
    - clr_stats (input, 1): synchronously zeroes err_count; clr_stats has priority over an increment in the same cycle.
  - rst clears err_flag and err_count.
- When undefined: these ports and the exact-sum logic do not exist. Core behaviour is identical.

Test Plan (WIDTH=32, LMAX=16):
- Approx, no carry: a=0x0000000F, b=0x00000001, mode=1, L=4 -> sum=0x0000000F, cout=0, out_valid 2 cycles after acceptance. With the monitor enabled, err_flag=1 and err_count goes 0->1.
- Approx, speculated carry: a=0x00008000, b=0x00008000, mode=1, L=16 -> sum=0x00018000, cout=0. The exact result would be 0x00010000.
- Exact wrap: a=0xFFFFFFFF, b=0x00000001, mode=0 -> sum=0x00000000, cout=1. With the monitor enabled, err_flag=0.
- Clamp: a=0x000000FF, b=0x00000001, mode=1, approx_len=20 -> treated as L=16: sum=0x000000FF, cout=0.
- Backpressure: in_valid held high with incrementing a and b=0, out_ready=0 for 4 cycles.
  - Expect in_ready to fall after 2 acceptances.
  - sum stays stable while stalled.
  - After out_ready=1, results appear in order with no loss and 1/cycle.
- Reset mid-operation: accept 2 beats, assert rst for 1 cycle -> out_valid=0, sum=0, cout=0, no stale results emerge. The next beat a=3, b=4, mode=0 -> sum=7 after 2 cycles.
